// File: rtl/up_adc_bus_pkg.sv
// Shared types and constants for the ADC up-bus combiner: FSM encoding,
// default timeout read-back word and the error counter width.
package up_adc_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_WAIT = 2'd1,
      ST_RD_WAIT = 2'd2
   } bus_state_e;

   localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hdead_dead;
   localparam int          ERR_CNT_W             = 16;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/up_adc_bus_timer.sv
// Loadable down-counter; expired_o flags a zero count while enabled so the
// owner can self-complete a transaction that no slave answered.
module up_adc_bus_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expired_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   assign expired_o = en_i && (count_q == '0);

endmodule

// File: rtl/up_adc_bus_combiner.sv
// Up-bus fan-out/fan-in for the ADC register slaves: one transaction in flight,
// write-before-read arbitration, ack timeout and sticky bus-error flags.
module up_adc_bus_combiner
   import up_adc_bus_pkg::*;
#(
   parameter int          NUM_SLAVES    = 3,
   parameter int          NUM_CHANNELS  = 2,
   parameter int          TIMEOUT       = 255,
   parameter logic [31:0] TIMEOUT_RDATA = TIMEOUT_RDATA_DEFAULT
) (
   input  logic                     up_clk,
   input  logic                     up_rstn,
   input  logic                     up_wreq,
   input  logic [13:0]              up_waddr,
   input  logic [31:0]              up_wdata,
   output logic                     up_wack,
   input  logic                     up_rreq,
   input  logic [13:0]              up_raddr,
   output logic [31:0]              up_rdata,
   output logic                     up_rack,
   output logic                     s_wreq,
   output logic [13:0]              s_waddr,
   output logic [31:0]              s_wdata,
   input  logic [NUM_SLAVES-1:0]    s_wack,
   output logic                     s_rreq,
   output logic [13:0]              s_raddr,
   input  logic [32*NUM_SLAVES-1:0] s_rdata,
   input  logic [NUM_SLAVES-1:0]    s_rack,
   input  logic [NUM_CHANNELS-1:0]  ch_pn_err,
   input  logic [NUM_CHANNELS-1:0]  ch_pn_oos,
   input  logic [NUM_CHANNELS-1:0]  ch_or,
   output logic                     up_status_pn_err,
   output logic                     up_status_pn_oos,
   output logic                     up_status_or,
   input  logic                     up_err_clr,
   output logic                     up_err_timeout,
   output logic                     up_err_multi,
   output logic                     up_err_collide,
   output logic [15:0]              up_timeout_count
);

   localparam int TW = $clog2(TIMEOUT + 1);

   bus_state_e            state_q, state_d;
   logic                  s_wreq_q, s_wreq_d, s_rreq_q, s_rreq_d;
   logic [13:0]           waddr_q, waddr_d, raddr_q, raddr_d;
   logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
   logic                  pend_q, pend_d;
   logic [13:0]           pend_addr_q, pend_addr_d;
   logic                  wack_q, wack_d, rack_q, rack_d;
   logic                  err_to_q, err_multi_q, err_col_q;
   logic [ERR_CNT_W-1:0]  to_cnt_q;
   logic                  st_pn_err_q, st_pn_oos_q, st_or_q;
   logic                  timer_load, timer_expired;
   logic                  timeout_evt, multi_evt, collide_evt;
   logic [31:0]           rd_or;

   up_adc_bus_timer #(.W(TW)) u_timer (
      .clk        (up_clk),
      .rst_n      (up_rstn),
      .load_i     (timer_load),
      .load_val_i (TW'(TIMEOUT)),
      .en_i       (state_q != ST_IDLE),
      .expired_o  (timer_expired)
   );

   always_comb begin
      state_d     = state_q;
      s_wreq_d    = 1'b0;
      s_rreq_d    = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      raddr_d     = raddr_q;
      rdata_d     = rdata_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      wack_d      = 1'b0;
      rack_d      = 1'b0;
      timer_load  = 1'b0;
      timeout_evt = 1'b0;
      multi_evt   = 1'b0;
      collide_evt = 1'b0;
      rd_or       = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (s_rack[k]) rd_or = rd_or | s_rdata[32*k +: 32];
      end
      case (state_q)
         ST_IDLE: begin
            // A pending read owns the bus this cycle; anything new is dropped.
            if (pend_q) begin
               s_rreq_d    = 1'b1;
               raddr_d     = pend_addr_q;
               pend_d      = 1'b0;
               state_d     = ST_RD_WAIT;
               timer_load  = 1'b1;
               collide_evt = up_wreq | up_rreq;
            end else if (up_wreq) begin
               s_wreq_d   = 1'b1;
               waddr_d    = up_waddr;
               wdata_d    = up_wdata;
               state_d    = ST_WR_WAIT;
               timer_load = 1'b1;
               if (up_rreq) begin
                  pend_d      = 1'b1;
                  pend_addr_d = up_raddr;
               end
            end else if (up_rreq) begin
               s_rreq_d   = 1'b1;
               raddr_d    = up_raddr;
               state_d    = ST_RD_WAIT;
               timer_load = 1'b1;
            end
         end
         ST_WR_WAIT: begin
            collide_evt = up_wreq | up_rreq;
            if (|s_wack) begin
               wack_d    = 1'b1;
               state_d   = ST_IDLE;
               multi_evt = (s_wack & (s_wack - NUM_SLAVES'(1))) != '0;
            end else if (timer_expired) begin
               wack_d      = 1'b1;
               state_d     = ST_IDLE;
               timeout_evt = 1'b1;
            end
         end
         ST_RD_WAIT: begin
            collide_evt = up_wreq | up_rreq;
            if (|s_rack) begin
               rack_d    = 1'b1;
               rdata_d   = rd_or;
               state_d   = ST_IDLE;
               multi_evt = (s_rack & (s_rack - NUM_SLAVES'(1))) != '0;
            end else if (timer_expired) begin
               rack_d      = 1'b1;
               rdata_d     = TIMEOUT_RDATA;
               state_d     = ST_IDLE;
               timeout_evt = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         state_q     <= ST_IDLE;
         s_wreq_q    <= 1'b0;
         s_rreq_q    <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         raddr_q     <= '0;
         rdata_q     <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         wack_q      <= 1'b0;
         rack_q      <= 1'b0;
         err_to_q    <= 1'b0;
         err_multi_q <= 1'b0;
         err_col_q   <= 1'b0;
         to_cnt_q    <= '0;
         st_pn_err_q <= 1'b0;
         st_pn_oos_q <= 1'b0;
         st_or_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_wreq_q    <= s_wreq_d;
         s_rreq_q    <= s_rreq_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         raddr_q     <= raddr_d;
         rdata_q     <= rdata_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         wack_q      <= wack_d;
         rack_q      <= rack_d;
         // A set event in the same cycle as a clear leaves the flag set.
         err_to_q    <= timeout_evt | (err_to_q    & ~up_err_clr);
         err_multi_q <= multi_evt   | (err_multi_q & ~up_err_clr);
         err_col_q   <= collide_evt | (err_col_q   & ~up_err_clr);
         if (timeout_evt) to_cnt_q <= sat_inc(to_cnt_q);
         else if (up_err_clr) to_cnt_q <= '0;
         st_pn_err_q <= |ch_pn_err;
         st_pn_oos_q <= |ch_pn_oos;
         st_or_q     <= |ch_or;
      end
   end

   assign up_wack          = wack_q;
   assign up_rack          = rack_q;
   assign up_rdata         = rdata_q;
   assign s_wreq           = s_wreq_q;
   assign s_waddr          = waddr_q;
   assign s_wdata          = wdata_q;
   assign s_rreq           = s_rreq_q;
   assign s_raddr          = raddr_q;
   assign up_err_timeout   = err_to_q;
   assign up_err_multi     = err_multi_q;
   assign up_err_collide   = err_col_q;
   assign up_timeout_count = to_cnt_q;
   assign up_status_pn_err = st_pn_err_q;
   assign up_status_pn_oos = st_pn_oos_q;
   assign up_status_or     = st_or_q;

endmodule

// File: doc/up_adc_bus_combiner.md
Name: up_adc_bus_combiner

Overview:
- Parametrised up-bus fan-out/fan-in stage between up_axi and the N register slaves of an ADC core (per-channel slaves plus up_adc_common).
- Successor to the fixed three-slave OR-combiner in the ADC top level.
- Adds: configurable slave and channel count, single-outstanding transaction sequencing, write/read arbitration, an ack timeout with a fixed error read-back, and sticky bus-error bookkeeping.

Parameters:
- NUM_SLAVES, 3, number of register slaves on the bus (1..16).
- NUM_CHANNELS, 2, number of channel status inputs reduced (1..32).
- TIMEOUT, 255, cycles to wait for a slave ack before self-acking (>=4).
- TIMEOUT_RDATA, 32'hdead_dead, read data returned on timeout.

Ports:
- up_clk  in  1  register-bus clock.
- up_rstn  in  1  asynchronous active-low reset.
- up_wreq  in  1  master write request, 1-cycle pulse.
- up_waddr  in  14  master write address.
- up_wdata  in  32  master write data.
- up_wack  out  1  master write ack, 1-cycle pulse.
- up_rreq  in  1  master read request, 1-cycle pulse.
- up_raddr  in  14  master read address.
- up_rdata  out  32  master read data, valid with up_rack.
- up_rack  out  1  master read ack, 1-cycle pulse.
- s_wreq  out  1  broadcast write request to all slaves.
- s_waddr  out  14  broadcast write address.
- s_wdata  out  32  broadcast write data.
- s_wack  in  NUM_SLAVES  per-slave write ack.
- s_rreq  out  1  broadcast read request.
- s_raddr  out  14  broadcast read address.
- s_rdata  in  32*NUM_SLAVES  per-slave read data, slave k at [32k+31:32k]; zero when not acking.
- s_rack  in  NUM_SLAVES  per-slave read ack.
- ch_pn_err / ch_pn_oos / ch_or  in  NUM_CHANNELS each  per-channel status.
- up_status_pn_err / up_status_pn_oos / up_status_or  out  1 each  registered OR reductions.
- up_err_clr  in  1  clears sticky error flags and the counter.
- up_err_timeout / up_err_multi / up_err_collide  out  1 each  sticky error flags.
- up_timeout_count  out  16  saturating count of timeouts.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pending-read latch empty, counter 0.
- FSM states: IDLE, WR_WAIT, RD_WAIT.
- IDLE + up_wreq: latch address and data, drive s_wreq for exactly 1 cycle on the next edge, go to WR_WAIT, load the timer.
- IDLE + up_rreq alone: same flow on the read side, go to RD_WAIT.
- IDLE + up_wreq and up_rreq in the same cycle: write issues first. Read address is latched as pending and issued on the cycle after up_wack, which is the cycle the FSM returns to IDLE.
- WR_WAIT + any s_wack bit: up_wack pulses on the next edge, FSM returns to IDLE.
- RD_WAIT + any s_rack bit: up_rdata <= OR of s_rdata over acking slaves; up_rack pulses on the next edge; FSM returns to IDLE.
- Latency: request cycle 0, s_*req cycle 1, earliest slave ack cycle 2, master ack cycle 3.
- Timeout: timer width $clog2(TIMEOUT+1).
  - Timer counts down each cycle in a WAIT state.
  - If it reaches 0 with no ack, self-ack on the next edge: up_wack, or up_rack with up_rdata=TIMEOUT_RDATA.
  - Sets up_err_timeout; up_timeout_count += 1, saturating at 16'hffff.
- Ack on the same cycle the timer reaches 0: ack wins, no timeout recorded.
- More than one ack bit set in a single cycle: data OR-combined, transaction completes normally, up_err_multi set.
- Acks arriving in IDLE (stray or late after a timeout): ignored.
- New master request while in a WAIT state, or while a read is pending: dropped, up_err_collide set.
- up_rdata holds its value between acks. up_wack, up_rack, s_wreq and s_rreq are never high for more than 1 cycle.
- up_err_clr: clears flags and counter on the next edge. A simultaneous set event wins over the clear.
- Status outputs: 1-cycle registered OR of the channel vectors, independent of the FSM.
- up_rstn asserted mid-transaction: immediate return to reset values, pending read discarded, no ack issued.

Decomposition:
- Shared package up_adc_bus_pkg: FSM state encoding, default TIMEOUT_RDATA, counter width 16.
- One sub-module, up_adc_bus_timer: loadable down-counter with expiry pulse.
- Ack/data reduction and the status ORs stay inline.

Test Plan:
- Single write, slave 2 acks 1 cycle after s_wreq -> s_wreq at cycle 1, up_wack at cycle 3, no error flags.
- Read where slave 1 returns 32'h0000_1234 -> up_rack at cycle 3 with up_rdata=32'h0000_1234, held afterwards.
- Read with no slave response, TIMEOUT=8 -> up_rack after timer expiry with up_rdata=32'hdead_dead, up_err_timeout=1, up_timeout_count=1; a late s_rack afterwards is ignored.
- up_wreq and up_rreq in the same cycle -> write completes first; s_rreq issues the cycle after up_wack; read completes normally.
- Slaves 0 and 1 ack together with data 32'h00ff and 32'hff00 -> up_rdata=32'hffff, up_err_multi=1; up_err_clr then clears it.
- Assert up_rstn low during WR_WAIT -> no up_wack; after release, a fresh read completes at cycle 3.
